// File: rtl/decoder_2x4_hold.sv
// decoder_2x4_hold: 2-to-4 one-hot decoder with a valid/ready input handshake.
// Each accepted code is presented on out for HOLD_CYCLES enabled cycles. A new
// code may be accepted in the last held cycle, so words can follow each other
// with no gap. en low freezes all state.
module decoder_2x4_hold #(
    parameter int unsigned HOLD_CYCLES = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       en,
    input  logic       in_valid,
    input  logic [1:0] in,
    output logic       in_ready,
    output logic [3:0] out,
    output logic       out_valid,
    output logic [7:0] accept_cnt
);

    typedef enum logic {
        IDLE,
        HOLD
    } state_t;

    localparam logic [7:0] HOLD_LOAD = 8'(HOLD_CYCLES);

    state_t     state;
    state_t     state_nxt;
    logic [7:0] hold_cnt;
    logic [7:0] hold_cnt_nxt;
    logic [3:0] out_nxt;
    logic       out_valid_nxt;
    logic [7:0] accept_cnt_nxt;
    logic       last_hold;
    logic       accept;

    assign last_hold = (state == HOLD) && (hold_cnt == 8'd1);
    assign accept    = in_valid & in_ready;

    // Ready when idle or in the final held cycle; never while frozen or in reset.
    always_comb begin
        in_ready = en & rst_n & ((state == IDLE) | last_hold);
    end

    // Next-state and next-output logic; everything holds unless enabled.
    always_comb begin
        state_nxt      = state;
        hold_cnt_nxt   = hold_cnt;
        out_nxt        = out;
        out_valid_nxt  = out_valid;
        accept_cnt_nxt = accept_cnt;

        if (en) begin
            if (accept) begin
                // Accepting in the last held cycle reloads directly: no zero word.
                state_nxt      = HOLD;
                hold_cnt_nxt   = HOLD_LOAD;
                out_nxt        = 4'b0001 << in;
                out_valid_nxt  = 1'b1;
                accept_cnt_nxt = accept_cnt + 8'd1;
            end else begin
                case (state)
                    IDLE: begin
                        state_nxt = IDLE;
                    end
                    HOLD: begin
                        if (hold_cnt == 8'd1) begin
                            state_nxt     = IDLE;
                            hold_cnt_nxt  = '0;
                            out_nxt       = '0;
                            out_valid_nxt = 1'b0;
                        end else begin
                            hold_cnt_nxt = hold_cnt - 8'd1;
                        end
                    end
                    default: begin
                        state_nxt     = IDLE;
                        hold_cnt_nxt  = '0;
                        out_nxt       = '0;
                        out_valid_nxt = 1'b0;
                    end
                endcase
            end
        end
    end

    // State and output registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            hold_cnt   <= '0;
            out        <= '0;
            out_valid  <= 1'b0;
            accept_cnt <= '0;
        end else begin
            state      <= state_nxt;
            hold_cnt   <= hold_cnt_nxt;
            out        <= out_nxt;
            out_valid  <= out_valid_nxt;
            accept_cnt <= accept_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_decoder_2x4_hold.sv
// Testbench for decoder_2x4_hold: directed scenarios plus random traffic,
// checked every cycle against a word/remaining-cycles reference model.
module tb_decoder_2x4_hold;

    localparam int unsigned HOLD = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       en = 1'b0;
    logic       in_valid = 1'b0;
    logic [1:0] in = 2'd0;
    logic       in_ready;
    logic [3:0] out;
    logic       out_valid;
    logic [7:0] accept_cnt;

    int checks = 0;
    int errors = 0;

    // Reference model: remaining held cycles, current word, accept count.
    int         m_rem = 0;
    logic [3:0] m_word = 4'd0;
    int         m_cnt = 0;
    bit         last_acc = 1'b0;

    decoder_2x4_hold #(.HOLD_CYCLES(HOLD)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .en         (en),
        .in_valid   (in_valid),
        .in         (in),
        .in_ready   (in_ready),
        .out        (out),
        .out_valid  (out_valid),
        .accept_cnt (accept_cnt)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // One clock cycle: drive inputs, check ready, advance model, check outputs.
    task automatic step(input bit e, input bit r, input bit v, input logic [1:0] code);
        bit ready;
        @(negedge clk);
        en = e;
        rst_n = r;
        in_valid = v;
        in = code;
        #1;
        ready = e && r && (m_rem <= 1);
        check("in_ready", {31'd0, in_ready}, {31'd0, ready});
        @(posedge clk);
        last_acc = 1'b0;
        if (!r) begin
            m_rem = 0;
            m_word = 4'd0;
            m_cnt = 0;
        end else if (e) begin
            if (v && ready) begin
                m_rem = HOLD;
                m_word = 4'd1 << code;
                m_cnt = (m_cnt + 1) % 256;
                last_acc = 1'b1;
            end else if (m_rem > 0) begin
                m_rem = m_rem - 1;
            end
        end
        #1;
        check("out", {28'd0, out}, {28'd0, (m_rem > 0) ? m_word : 4'd0});
        check("out_valid", {31'd0, out_valid}, {31'd0, m_rem > 0});
        check("accept_cnt", {24'd0, accept_cnt}, m_cnt);
    endtask

    // Hold in_valid with a code until accepted; bounded wait.
    task automatic send(input logic [1:0] code);
        int n = 0;
        do begin
            step(1'b1, 1'b1, 1'b1, code);
            n++;
        end while (!last_acc && n < 3 * HOLD + 4);
        if (!last_acc) begin
            checks++;
            errors++;
            $display("FAIL send_timeout: code %0d not accepted within %0d cycles", code, n);
        end
    endtask

    initial begin
        // Reset for 2 cycles with noise on other inputs.
        step(1'b1, 1'b0, 1'b1, 2'd3);
        step(1'b0, 1'b0, 1'b1, 2'd1);

        // All four codes, back-to-back where possible, then drain.
        for (int c = 0; c < 4; c++) send(2'(c));
        repeat (HOLD + 1) step(1'b1, 1'b1, 1'b0, 2'd0);
        check("cnt_after_4", {24'd0, accept_cnt}, 32'd4);
        check("idle_out", {28'd0, out}, 32'd0);

        // Back-to-back 2 then 1 with no zero gap.
        send(2'd2);
        send(2'd1);
        check("b2b_word", {28'd0, out}, 32'h2);
        check("b2b_valid", {31'd0, out_valid}, 32'd1);
        repeat (HOLD + 1) step(1'b1, 1'b1, 1'b0, 2'd0);

        // Enable freeze during hold of code 3, with a request pending.
        send(2'd3);
        step(1'b1, 1'b1, 1'b0, 2'd0);
        repeat (5) step(1'b0, 1'b1, 1'b1, 2'd0);
        check("freeze_out", {28'd0, out}, 32'h8);
        repeat (HOLD) step(1'b1, 1'b1, 1'b0, 2'd0);
        check("freeze_done", {28'd0, out}, 32'd0);

        // Ignored request mid-hold.
        send(2'd2);
        step(1'b1, 1'b1, 1'b1, 2'd0);
        check("ignored_out", {28'd0, out}, 32'h4);
        send(2'd0);
        repeat (HOLD + 1) step(1'b1, 1'b1, 1'b0, 2'd0);

        // Reset mid-hold.
        send(2'd1);
        step(1'b1, 1'b0, 1'b1, 2'd2);
        check("rst_mid_out", {28'd0, out}, 32'd0);
        check("rst_mid_valid", {31'd0, out_valid}, 32'd0);
        check("rst_mid_cnt", {24'd0, accept_cnt}, 32'd0);

        // Random traffic.
        for (int i = 0; i < 1500; i++) begin
            step(($urandom_range(0, 9) != 0), ($urandom_range(0, 49) != 0),
                 ($urandom_range(0, 9) < 6), 2'($urandom_range(0, 3)));
        end

        // Counter wrap.
        step(1'b1, 1'b0, 1'b0, 2'd0);
        for (int k = 0; k < 255; k++) send(2'($urandom_range(0, 3)));
        check("cnt_255", {24'd0, accept_cnt}, 32'd255);
        send(2'd3);
        check("cnt_wrap", {24'd0, accept_cnt}, 32'd0);
        repeat (HOLD + 1) step(1'b1, 1'b1, 1'b0, 2'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
